instr_fetch_unit: RTL

Instruction fetch stage directly upstream of the decode/control unit. It holds the PC and issues word requests to instruction memory over a req/gnt/rvalid handshake. Returned words are buffered with their PC in a small FIFO and presented to decode over valid/ready, with id_opcode driving the control unit's opcode input. A branch/jump redirect from execute flushes the buffer and any in-flight response.

---
 rtl/riscv_core_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/riscv_core_pkg.sv
// Shared core definitions: datapath width, reset PC, RV32 opcodes and fetch FSM encoding.
package riscv_core_pkg;

   localparam int unsigned    CORE_XLEN        = 32;
   localparam logic [31:0]    DEFAULT_RESET_PC = 32'h0000_0000;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, instr} entries with flush; head reads 0 when empty.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic [WIDTH-1:0]           head
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             full_s;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_s    = (count_r == CNT_W'(DEPTH));
   assign do_pop_s  = pop & ~flush & (count_r != {CNT_W{1'b0}});
   // A push into a full buffer is only legal when the head leaves in the same cycle.
   assign do_push_s = push & ~flush & (~full_s | do_pop_s);

   assign count = count_r;
   assign head  = (count_r != {CNT_W{1'b0}}) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= {WIDTH{1'b0}};
      end else if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem req/gnt/rvalid, fetch buffer to decode.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_stall counters.
module instr_fetch_unit
   import riscv_core_pkg::*;
#(
   parameter int unsigned     XLEN       = CORE_XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [6:0]      id_opcode
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_stall
`endif
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   fetch_state_e      state_r;
   fetch_state_e      state_nxt_s;
   logic [XLEN-1:0]   pc_r;
   logic [XLEN-1:0]   pc_seq_s;
   logic [XLEN-1:0]   pc_nxt_s;
   logic [XLEN-1:0]   req_pc_r;
   logic [XLEN-1:0]   req_pc_nxt_s;
   logic [CNT_W-1:0]  count_s;
   logic [2*XLEN-1:0] head_s;
   logic              outstanding_s;
   logic              space_s;
   logic              req_s;
   logic              push_s;
   logic              pop_s;
   logic [1:0]        redirect_lsb_unused_s;

   assign redirect_lsb_unused_s = redirect_pc[1:0];

   assign outstanding_s = (state_r != REQ);
   assign space_s  = ({1'b0, count_s} + {{CNT_W{1'b0}}, outstanding_s}) < SUM_W'(FIFO_DEPTH);
   assign id_valid = (count_s != {CNT_W{1'b0}});
   assign pop_s    = id_valid & id_ready;
   assign imem_req  = req_s & rst_n;
   assign imem_addr = pc_r;
   assign pc_nxt_s  = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : pc_seq_s;

   assign id_pc     = head_s[2*XLEN-1:XLEN];
   assign id_instr  = head_s[XLEN-1:0];
   assign id_opcode = head_s[6:0];

   // Next-state, request and push decode for the fetch FSM.
   always_comb begin
      state_nxt_s  = state_r;
      pc_seq_s     = pc_r;
      req_pc_nxt_s = req_pc_r;
      req_s        = 1'b0;
      push_s       = 1'b0;
      case (state_r)
         REQ: begin
            if (space_s) begin
               req_s = 1'b1;
               if (imem_gnt) begin
                  req_pc_nxt_s = pc_r;
                  pc_seq_s     = pc_r + XLEN'(4);
                  state_nxt_s  = redirect_valid ? DROP : WAIT;
               end else begin
                  state_nxt_s = REQ;
               end
            end else begin
               state_nxt_s = REQ;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               push_s      = ~redirect_valid;
               state_nxt_s = REQ;
            end else begin
               state_nxt_s = redirect_valid ? DROP : WAIT;
            end
         end
         DROP: begin
            // The response arriving here is the stale one, so a same-cycle redirect needs no second drop.
            if (imem_rvalid) begin
               state_nxt_s = REQ;
            end else begin
               state_nxt_s = DROP;
            end
         end
         default: state_nxt_s = REQ;
      endcase
   end

   // Fetch state, PC and the PC of the request in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= REQ;
         pc_r     <= {RESET_PC[XLEN-1:2], 2'b00};
         req_pc_r <= {XLEN{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         pc_r     <= pc_nxt_s;
         req_pc_r <= req_pc_nxt_s;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2*XLEN)
   ) u_fetch_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .flush (redirect_valid),
      .wdata ({req_pc_r, imem_rdata}),
      .count (count_s),
      .head  (head_s)
   );

`ifdef FETCH_PERF_CNT_EN
   // Delivered-instruction and decode-stall counters; both wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= 32'd0;
         perf_stall   <= 32'd0;
      end else begin
         if (pop_s)                 perf_fetched <= perf_fetched + 32'd1;
         if (id_valid && !id_ready) perf_stall   <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
